// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared definitions for the RV32M multiply/divide unit
//
// Holds the funct3 operation codes, the FSM state encoding and the
// architectural constants used for division special cases.

package muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam logic [31:0] MD_DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] MD_INT_MIN   = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 multiply or divide iteration
//
// Ports:
//   div_mode_i  1  : 0 = shift-add multiply, 1 = restoring divide
//   acc_i      64  : multiply {partial_hi, multiplier_lo}, divide {remainder, quotient}
//   operand_i  32  : multiplicand (multiply) or divisor (divide) magnitude
//   acc_o      64  : accumulator after this iteration

module muldiv_step (
  input  logic        div_mode_i,
  input  logic [63:0] acc_i,
  input  logic [31:0] operand_i,
  output logic [63:0] acc_o
);

  logic [32:0] sum;
  logic [32:0] trial;
  logic [32:0] diff;

  always_comb begin
    acc_o = acc_i;
    sum   = '0;
    trial = '0;
    diff  = '0;
    if (div_mode_i) begin
      // Shift the next dividend bit into the remainder; 33 bits because the
      // shifted remainder can exceed 32 bits before the subtract.
      trial = {acc_i[63:32], acc_i[31]};
      diff  = trial - {1'b0, operand_i};
      if (!diff[32]) begin
        acc_o = {diff[31:0], acc_i[30:0], 1'b1};
      end else begin
        acc_o = {trial[31:0], acc_i[30:0], 1'b0};
      end
    end else begin
      // The carry out of the add becomes the new top bit after the shift.
      sum   = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, operand_i} : 33'd0);
      acc_o = {sum, acc_i[31:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle RV32M multiply/divide unit
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   MDstart                  : request, accepted in IDLE or DONE
//   MDfunct3                 : RV32M operation select
//   MDoperand1, MDoperand2   : rs1 / rs2 values, sampled only at accept
//   MDdestination_register   : rd, captured at accept
//   MDbusy                   : operation in flight
//   MDdone                   : one-cycle result-valid pulse
//   MDresult, MDrd_out       : result and its rd, held until replaced
//
// Build option MULDIV_FAST_MUL_EN: multiplies use one single-cycle product
// instead of 32 shift-add steps; division is unaffected.

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MDstart,
  input  logic [2:0]      MDfunct3,
  input  logic [XLEN-1:0] MDoperand1,
  input  logic [XLEN-1:0] MDoperand2,
  input  logic [4:0]      MDdestination_register,
  output logic            MDbusy,
  output logic            MDdone,
  output logic [XLEN-1:0] MDresult,
  output logic [4:0]      MDrd_out
);

  md_state_e   state_q;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q;
  logic [31:0] opnd_q;
  logic        div_q;
  logic        hi_q;
  logic        neg_q;
  logic [4:0]  rd_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] result_q;
  logic [4:0]  rd_out_q;

  logic        a_signed, b_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        req_div, req_hi, req_neg, div0, ovf;
  logic [63:0] step_acc;
  logic [63:0] acc_neg, mul_src;
  logic [31:0] div_word, fix_word;

  // Request decode: operand signedness, result sign and word selection.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (MDfunct3)
      MD_MULH, MD_DIV, MD_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      MD_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
    a_neg   = a_signed & MDoperand1[31];
    b_neg   = b_signed & MDoperand2[31];
    a_mag   = a_neg ? (~MDoperand1 + 32'd1) : MDoperand1;
    b_mag   = b_neg ? (~MDoperand2 + 32'd1) : MDoperand2;
    req_div = MDfunct3[2];
    req_hi  = req_div ? MDfunct3[1] : (MDfunct3 != MD_MUL);
    // Remainder follows the dividend; quotient and product follow both.
    req_neg = (req_div && MDfunct3[1]) ? a_neg : (a_neg ^ b_neg);
    div0    = req_div && (MDoperand2 == '0);
    ovf     = req_div && !MDfunct3[0] && (MDoperand1 == MD_INT_MIN)
              && (MDoperand2 == 32'hFFFF_FFFF);
  end

  muldiv_step u_step (
    .div_mode_i (div_q),
    .acc_i      (acc_q),
    .operand_i  (opnd_q),
    .acc_o      (step_acc)
  );

`ifdef MULDIV_FAST_MUL_EN
  // Magnitudes are widened to 33-bit signed so the same product covers
  // every multiply flavour; sign is restored in FIX.
  logic signed [63:0] fast_prod;
  assign fast_prod = 64'($signed({1'b0, opnd_q})) * 64'($signed({1'b0, acc_q[31:0]}));
`endif

  // Sign fix-up. A product must be negated as a full 64-bit value so the
  // high word picks up the borrow from the low word; quotient and remainder
  // are independent words and are negated on their own.
  always_comb begin
    acc_neg  = ~acc_q + 64'd1;
    mul_src  = neg_q ? acc_neg : acc_q;
    div_word = hi_q ? acc_q[63:32] : acc_q[31:0];
    if (div_q) begin
      fix_word = neg_q ? (~div_word + 32'd1) : div_word;
    end else begin
      fix_word = hi_q ? mul_src[63:32] : mul_src[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      div_q    <= 1'b0;
      hi_q     <= 1'b0;
      neg_q    <= 1'b0;
      rd_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (MDstart) begin
            rd_q   <= MDdestination_register;
            div_q  <= req_div;
            hi_q   <= req_hi;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (div0 || ovf) begin
              // Final {remainder, quotient} loaded directly; FIX just selects.
              acc_q   <= div0 ? {MDoperand1, MD_DIV0_QUOT} : {32'd0, MD_INT_MIN};
              neg_q   <= 1'b0;
              state_q <= ST_FIX;
            end else begin
              acc_q   <= {32'd0, req_div ? a_mag : b_mag};
              opnd_q  <= req_div ? b_mag : a_mag;
              neg_q   <= req_neg;
              state_q <= ST_CALC;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_CALC: begin
`ifdef MULDIV_FAST_MUL_EN
          if (!div_q) begin
            acc_q   <= fast_prod;
            state_q <= ST_FIX;
          end else begin
            acc_q <= step_acc;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_q <= ST_FIX;
          end
`else
          acc_q <= step_acc;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= ST_FIX;
`endif
        end
        ST_FIX: begin
          result_q <= fix_word;
          rd_out_q <= rd_q;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign MDbusy   = busy_q;
  assign MDdone   = done_q;
  assign MDresult = result_q;
  assign MDrd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit

module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        MDstart;
  logic [2:0]  MDfunct3;
  logic [31:0] MDoperand1;
  logic [31:0] MDoperand2;
  logic [4:0]  MDdestination_register;
  logic        MDbusy;
  logic        MDdone;
  logic [31:0] MDresult;
  logic [4:0]  MDrd_out;

  int errors = 0;
  int checks = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .MDstart                (MDstart),
    .MDfunct3               (MDfunct3),
    .MDoperand1             (MDoperand1),
    .MDoperand2             (MDoperand2),
    .MDdestination_register (MDdestination_register),
    .MDbusy                 (MDbusy),
    .MDdone                 (MDdone),
    .MDresult               (MDresult),
    .MDrd_out               (MDrd_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Architectural RV32M result, from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, ub_s, r;
    logic [63:0] p;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ub_s = longint'({32'd0, b});
    p    = '0;
    r    = 0;
    case (f)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb;                 return p[63:32]; end
      3'd2: begin p = sa * ub_s;               return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        r = sa / sb; p = r; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        r = sa % sb; p = r; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Cycles from the accept edge to the edge that raises MDdone.
  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 2;
`endif
    return 33;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input bit pulse_mid);
    logic [31:0] exp_res;
    int          exp_lat;
    int          k;
    exp_res = ref_result(f, a, b);
    exp_lat = ref_latency(f, a, b);
    @(negedge clk);
    MDstart = 1'b1; MDfunct3 = f; MDoperand1 = a; MDoperand2 = b;
    MDdestination_register = rd;
    @(posedge clk);
    @(negedge clk);
    MDstart = 1'b0; MDoperand1 = $urandom; MDoperand2 = $urandom;
    MDfunct3 = 3'($urandom); MDdestination_register = 5'($urandom);
    k = 0;
    check({tag, " busy_after_accept"}, 32'(MDbusy), 32'd1);
    while (MDdone !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
      MDstart = (pulse_mid && k == 5);
    end
    MDstart = 1'b0;
    check({tag, " latency"}, 32'(k), 32'(exp_lat));
    check({tag, " result"}, MDresult, exp_res);
    check({tag, " rd"}, 32'(MDrd_out), 32'(rd));
    check({tag, " busy_in_done"}, 32'(MDbusy), 32'd0);
    @(negedge clk);
    check({tag, " done_one_cycle"}, 32'(MDdone), 32'd0);
    check({tag, " idle_after"}, 32'(MDbusy), 32'd0);
  endtask

  task automatic abort_test();
    int pulses;
    @(negedge clk);
    MDstart = 1'b1; MDfunct3 = 3'd5; MDoperand1 = 32'd1000; MDoperand2 = 32'd3;
    MDdestination_register = 5'd17;
    @(posedge clk);
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      MDstart = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort busy", 32'(MDbusy), 32'd0);
    check("abort done", 32'(MDdone), 32'd0);
    check("abort result", MDresult, 32'd0);
    check("abort rd", 32'(MDrd_out), 32'd0);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (MDdone === 1'b1) pulses++;
    end
    check("abort no_done", 32'(pulses), 32'd0);
  endtask

  task automatic back_to_back_test();
    int k, k1;
    @(negedge clk);
    MDstart = 1'b1; MDfunct3 = 3'd5; MDoperand1 = 32'd100; MDoperand2 = 32'd7;
    MDdestination_register = 5'd5;
    @(posedge clk);
    @(negedge clk);
    MDfunct3 = 3'd7; MDdestination_register = 5'd9;
    k = 0;
    while (MDdone !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    k1 = k;
    check("b2b first_latency", 32'(k1), 32'd33);
    check("b2b first_result", MDresult, 32'd14);
    check("b2b first_rd", 32'(MDrd_out), 32'd5);
    @(negedge clk);
    k++;
    MDstart = 1'b0;
    check("b2b second_busy", 32'(MDbusy), 32'd1);
    while (MDdone !== 1'b1 && k < k1 + 60) begin
      @(negedge clk);
      k++;
    end
    check("b2b spacing", 32'(k - k1), 32'd34);
    check("b2b second_result", MDresult, 32'd2);
    check("b2b second_rd", 32'(MDrd_out), 32'd9);
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    int          sel;
    rst = 1'b1; MDstart = 1'b0; MDfunct3 = '0; MDoperand1 = '0; MDoperand2 = '0;
    MDdestination_register = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(MDbusy), 32'd0);
    check("reset done", 32'(MDdone), 32'd0);
    check("reset result", MDresult, 32'd0);
    check("reset rd", 32'(MDrd_out), 32'd0);
    rst = 1'b0;

    run_op("mul", 3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1, 1'b0);
    run_op("mulh", 3'd1, 32'h0000_0007, 32'hFFFF_FFFD, 5'd2, 1'b1);
    run_op("mulhu", 3'd3, 32'h0000_0007, 32'hFFFF_FFFD, 5'd3, 1'b0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b0);
    run_op("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b1);
    run_op("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b0);
    run_op("divu", 3'd5, 32'd100, 32'd7, 5'd8, 1'b0);
    run_op("remu", 3'd7, 32'd100, 32'd7, 5'd10, 1'b0);
    run_op("div_by0", 3'd4, 32'h1234_5678, 32'd0, 5'd11, 1'b0);
    run_op("rem_by0", 3'd6, 32'h1234_5678, 32'd0, 5'd12, 1'b0);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b0);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b0);

    abort_test();
    run_op("after_abort", 3'd5, 32'd1000, 32'd3, 5'd18, 1'b0);
    back_to_back_test();

    for (int i = 0; i < 40; i++) begin
      f   = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'hFFFF_FFFF - 32'($urandom_range(0, 100));
        default: ;
      endcase
      run_op($sformatf("rand%0d_f%0d", i, f), f, a, b, 5'($urandom), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
